// File: rtl/ascon_pkg.sv
// Shared Ascon types: the core control bundle, arbiter states and the
// round-robin pick helper used by the core arbiter.
package ascon_pkg;

    typedef logic [63:0] ascon_word_t;

    // Control bundle driven into the Ascon permutation core.
    typedef struct packed {
        logic        start_perm;
        logic        round_config;
        logic [2:0]  word_sel;
        ascon_word_t data;
        logic        write_en;
        logic [1:0]  core_in_data_sel;
        logic [1:0]  xor_sel;
    } core_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN0,
        ST_OWN1,
        ST_DRAIN
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic idx;
    } arb_pick_t;

    // Round-robin choice between the pending requests. On a tie the
    // requester that was not granted last time wins.
    function automatic arb_pick_t arb_pick(input logic [1:0] req, input logic last);
        arb_pick_t p;
        p.valid = |req;
        if (req == 2'b11) begin
            p.idx = ~last;
        end else begin
            p.idx = req[1];
        end
        return p;
    endfunction

endpackage

// File: rtl/ascon_core_arbiter.sv
// Hands the single Ascon permutation core to either the AEAD FSM (0) or
// the hash FSM (1) for a whole operation, draining an in-flight
// permutation before handover, flagging protocol violations and counting
// accepted permutation starts.
module ascon_core_arbiter
    import ascon_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_i,
    input  core_ctrl_t       req0_ctrl_i,
    input  core_ctrl_t       req1_ctrl_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       ready_o,
    output core_ctrl_t       core_ctrl_o,
    input  logic             ascon_ready_i,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] perm_cnt_o
);

    arb_state_t state, state_nxt;
    logic       last, last_nxt;
    arb_pick_t  pick;
    arb_state_t pick_state;
    logic       violation;

    // Next-state and round-robin pointer selection.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        last_nxt   = last;
        pick       = arb_pick(req_i, last);
        pick_state = ST_IDLE;
        if (pick.valid) begin
            pick_state = pick.idx ? ST_OWN1 : ST_OWN0;
        end

        case (state)
            ST_IDLE: begin
                state_nxt = pick_state;
                if (pick.valid) last_nxt = pick.idx;
            end
            ST_OWN0, ST_OWN1: begin
                // Owner's own request bit is low here, so pick can only
                // select the other requester for a direct handover.
                if (!req_i[state == ST_OWN1]) begin
                    if (!ascon_ready_i) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt = pick_state;
                        if (pick.valid) last_nxt = pick.idx;
                    end
                end
            end
            ST_DRAIN: begin
                if (ascon_ready_i) begin
                    state_nxt = pick_state;
                    if (pick.valid) last_nxt = pick.idx;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and round-robin pointer; last = 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Output decode: grant, owner bundle mux and ready routing, zero latency.
    always_comb begin
        gnt_o       = 2'b00;
        ready_o     = 2'b00;
        core_ctrl_o = '0;
        case (state)
            ST_OWN0: begin
                gnt_o       = 2'b01;
                ready_o     = {1'b0, ascon_ready_i};
                core_ctrl_o = req0_ctrl_i;
            end
            ST_OWN1: begin
                gnt_o       = 2'b10;
                ready_o     = {ascon_ready_i, 1'b0};
                core_ctrl_o = req1_ctrl_i;
            end
            default: ;
        endcase
    end

    assign busy_o = (state != ST_IDLE);

    // A requester driving the core while it holds a request but no grant.
    assign violation =
        (req_i[0] & ~gnt_o[0] & (req0_ctrl_i.start_perm | req0_ctrl_i.write_en)) |
        (req_i[1] & ~gnt_o[1] & (req1_ctrl_i.start_perm | req1_ctrl_i.write_en));

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (violation) begin
            err_o <= 1'b1;
        end
    end

    // Saturating count of permutation starts accepted by the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perm_cnt_o <= '0;
        end else if (core_ctrl_o.start_perm && ascon_ready_i && (perm_cnt_o != '1)) begin
            perm_cnt_o <= perm_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: doc/ascon_core_arbiter.md
# ascon_core_arbiter

Shares the single Ascon permutation core between two control FSMs: the AEAD FSM (requester 0) and the hash FSM (requester 1). Each FSM holds ownership of the core for a whole operation. The arbiter grants ownership round-robin, muxes the owner's control bundle onto the core, and routes `ascon_ready_i` back to the owner only. It also drains an in-flight permutation before handing over, flags protocol violations and counts accepted permutations.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating permutation counter.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `req_i`, input, 2: ownership request; bit 0 is AEAD, bit 1 is hash. Held high for the whole operation.
- `req0_ctrl_i`, input, `core_ctrl_t`: AEAD control bundle.
- `req1_ctrl_i`, input, `core_ctrl_t`: hash control bundle.
- `gnt_o`, output, 2: registered one-hot grant.
- `ready_o`, output, 2: per-requester copy of `ascon_ready_i`, gated by ownership.
- `core_ctrl_o`, output, `core_ctrl_t`: bundle driven into the Ascon core.
- `ascon_ready_i`, input, 1: core idle/ready.
- `busy_o`, output, 1: state is not IDLE.
- `err_o`, output, 1: sticky protocol-violation flag.
- `perm_cnt_o`, output, `CNT_W`: saturating count of accepted permutation starts.

## Operation
- States: IDLE, OWN0, OWN1, DRAIN. Registered `last` (1 bit) records the most recently granted requester.
- **IDLE:**
  - `core_ctrl_o` = 0 and `ready_o` = 0.
  - One request pending: go to OWN of that requester.
  - Both requests pending: go to OWN of `!last`.
  - On any grant, set `last` to the granted index.
- **OWNx:**
  - `core_ctrl_o` = `reqx_ctrl_i`, combinational pass-through.
  - `ready_o[x]` = `ascon_ready_i`; the other bit of `ready_o` is 0.
  - `req_i[x]` still high: stay in OWNx.
  - `req_i[x]` low and `ascon_ready_i` = 0: go to DRAIN.
  - `req_i[x]` low, `ascon_ready_i` = 1 and the other request high: go directly to OWN of the other requester and update `last`.
  - `req_i[x]` low, `ascon_ready_i` = 1 and no other request: go to IDLE.
- **DRAIN:**
  - `core_ctrl_o` = 0 and `ready_o` = 0.
  - Leave when `ascon_ready_i` = 1, applying the same grant selection as IDLE in that cycle. Otherwise stay.
- **Violation:** `err_o` is set when, in any state, a non-owner bundle has `start_perm` or `write_en` = 1 while its own `req_i` bit is high but its `gnt_o` bit is low. Non-owner bundles are never forwarded regardless. `err_o` clears only on reset.
- **Counter:** `perm_cnt_o` increments when `core_ctrl_o.start_perm` & `ascon_ready_i` = 1. It saturates at all-ones and never wraps.
- `gnt_o` is a decode of the state: OWN0 gives 01, OWN1 gives 10, anything else gives 00.

## Timing
- **Reset values** (asynchronous `rst` forces all of these immediately, including mid-operation; a permutation already in the core is not aborted by this block):
  - state = IDLE, `last` = 1, so requester 0 wins the first tie.
  - `gnt_o` = 0, `ready_o` = 0, `core_ctrl_o` = 0.
  - `busy_o` = 0, `err_o` = 0, `perm_cnt_o` = 0.
- Request to grant: `req_i` sampled high in IDLE at edge N gives `gnt_o` high after edge N, i.e. 1 cycle.
- Release: `req_i` low at edge N gives `gnt_o` low after edge N.
- Handover with the core ready: the new owner's grant appears at the same edge the old one drops, with no dead cycle.
- A requester must not drive `start_perm` or `write_en` until it observes its `gnt_o` high.
- A requester may drop `req_i` while a permutation is in flight; DRAIN covers this case.
- Bundle pass-through and `ready_o` add zero latency.

## Structure
- `ascon_pkg` gains packed `core_ctrl_t` with fields in this order:
  - `start_perm` (1)
  - `round_config` (1)
  - `word_sel` (3)
  - `data` (`ascon_word_t`)
  - `write_en` (1)
  - `core_in_data_sel` (2)
  - `xor_sel` (2)
- `ascon_pkg` also gains `arb_state_t` for the four states.
- Single module. The arbitration decision is one combinational function reused by IDLE, DRAIN and the OWNx handover. No sub-module is needed.

## Test plan
- **Single request:** `req_i` = 01 in IDLE → `gnt_o` = 01 one cycle later. `core_ctrl_o.data` tracks `req0_ctrl_i.data` (e.g. 0x00400c0000000100). `ready_o` = {0, `ascon_ready_i`}.
- **Tie after reset:** `req_i` = 11 → OWN0 first. Drop `req_i[0]` with ready = 1 → `gnt_o` = 10 at the next edge, no IDLE cycle. A subsequent tie grants 0.
- **Drain:** in OWN1, pulse `start_perm`, then drop `req_i[1]` while `ascon_ready_i` = 0 for 12 cycles → state DRAIN, `gnt_o` = 00, `core_ctrl_o` = 0. When ready rises with `req_i[0]` high → `gnt_o` = 01 on the next edge.
- **Violation:** in OWN0, `req1_ctrl_i.start_perm` = 1 while `req_i[1]` = 1 → `err_o` = 1, core `start_perm` stays 0, `err_o` holds until `rst`.
- **Counter:** 5 accepted starts → `perm_cnt_o` = 5. With `CNT_W` = 4, 20 accepted starts → `perm_cnt_o` = 15.
- **Reset mid-operation:** assert `rst` in OWN1 between edges → all outputs 0 immediately. After release, `req_i` = 11 → `gnt_o` = 01.
